serial_frame_rx: RTL

Serial frame receiver that sits directly downstream of the serial-in/serial-out shift register and consumes its `serial_out` bitstream, one bit per clock. It detects a start bit, assembles DATA_W data bits LSB-first, optionally checks even parity, and validates the stop bit. Good frames go into a 2-entry output buffer drained through a valid/ready handshake. Errors are reported as single-cycle pulses.

---
 rtl/serial_frame_rx_if.sv | 11 +
 rtl/serial_frame_rx.sv | 125 ++++++++++++
 2 files changed

// File: rtl/serial_frame_rx_if.sv
// Output-side handshake bundle of serial_frame_rx: head-of-buffer word with valid/ready.
interface serial_frame_rx_if #(
    parameter int DATA_W = 8
);
    logic [DATA_W-1:0] data_out;
    logic              data_valid;
    logic              data_ready;

    modport master (output data_out, output data_valid, input data_ready);
    modport slave  (input data_out, input data_valid, output data_ready);
endinterface

// File: rtl/serial_frame_rx.sv
// Serial frame receiver: start=1, DATA_W bits LSB-first, optional even parity, stop=0; 2-entry output FIFO.
// Optional parity checking is enabled by defining SERIAL_FRAME_RX_PARITY_EN.
module serial_frame_rx #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              serial_in,
    serial_frame_rx_if.master rx,
    output logic              busy,
    output logic              framing_err,
    output logic              parity_err,
    output logic              overrun_err
);
    localparam int CNT_W = (DATA_W > 2) ? $clog2(DATA_W) : 1;

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] DATA   = 2'd1;
    localparam logic [1:0] PARITY = 2'd2;
    localparam logic [1:0] STOP   = 2'd3;

    logic [1:0]        state;
    logic [CNT_W-1:0]  bit_cnt;
    logic [DATA_W-1:0] shreg;
    logic [DATA_W-1:0] mem0;
    logic [DATA_W-1:0] mem1;
    logic [1:0]        count;
    logic              stop_edge;
    logic              par_bad;
    logic              frame_good;
    logic              pop;
    logic              push_ok;
    logic              overrun;

    function automatic logic parity_mismatch(input logic [DATA_W-1:0] d, input logic p);
        return (^d) ^ p;
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            bit_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (serial_in) begin
                        state   <= DATA;
                        bit_cnt <= '0;
                    end
                end
                DATA: begin
                    if (bit_cnt == CNT_W'(DATA_W - 1)) begin
                        bit_cnt <= '0;
`ifdef SERIAL_FRAME_RX_PARITY_EN
                        state   <= PARITY;
`else
                        state   <= STOP;
`endif
                    end else begin
                        bit_cnt <= bit_cnt + 1'b1;
                    end
                end
                PARITY:  state <= STOP;
                default: state <= IDLE;
            endcase
        end
    end

    // Datapath capture: data bits enter at the MSB so the first bit ends up in bit 0.
    always_ff @(posedge clk) begin
        if (state == DATA) shreg <= {serial_in, shreg[DATA_W-1:1]};
    end

`ifdef SERIAL_FRAME_RX_PARITY_EN
    logic par_bit;

    always_ff @(posedge clk) begin
        if (state == PARITY) par_bit <= serial_in;
    end

    assign par_bad = (state == STOP) && parity_mismatch(shreg, par_bit);
`else
    assign par_bad = 1'b0;
`endif

    assign stop_edge  = (state == STOP);
    assign frame_good = stop_edge && !serial_in && !par_bad;
    assign pop        = rx.data_valid && rx.data_ready;
    // A pop on the same edge frees a slot, so a full buffer still accepts the word.
    assign push_ok    = frame_good && ((count != 2'd2) || pop);
    assign overrun    = frame_good && (count == 2'd2) && !pop;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count       <= 2'd0;
            mem0        <= '0;
            framing_err <= 1'b0;
            parity_err  <= 1'b0;
            overrun_err <= 1'b0;
        end else begin
            framing_err <= stop_edge && serial_in;
            parity_err  <= par_bad;
            overrun_err <= overrun;
            case ({push_ok, pop})
                2'b10:   count <= count + 2'd1;
                2'b01:   count <= count - 2'd1;
                default: count <= count;
            endcase
            if (pop) begin
                if (count == 2'd2)  mem0 <= mem1;
                else if (push_ok)   mem0 <= shreg;
            end else if (push_ok && (count == 2'd0)) begin
                mem0 <= shreg;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok && (((count == 2'd1) && !pop) || ((count == 2'd2) && pop))) mem1 <= shreg;
    end

    assign rx.data_out   = mem0;
    assign rx.data_valid = (count != 2'd0);
    assign busy          = (state != IDLE);
endmodule
